huff_line_writer: RTL and testbench
===================================

# huff_line_writer

Downstream companion to the per-table bit-serial Huffman pair decoders. Accepts signed (x, y) pairs on the decoder's `axiov` strobe and buffers them in a small pair FIFO. Writes each pair as two consecutive frequency lines into the granule line RAM, then zero-fills the rest of the 576-line granule. Also throttles the upstream bit source so bursts of short codewords never overflow the buffer.

## Interface
- `NUM_LINES`, 576, frequency lines per granule.
- `SAMPLE_W`, 16, signed line sample width (matches decoder `x_val`/`y_val`).
- `ADDR_W`, 10, line address width.
- `FIFO_DEPTH`, 4, pair FIFO depth (power of two, ≥4).
- `clk`  in  1  single clock, all logic rising-edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  one-cycle pulse; latches `big_values`, begins granule.
- `big_values`  in  9  pair count for this granule; values >288 clamp to 288.
- `axiov`  in  1  decoder pair strobe, one pair per asserted cycle.
- `x_val`  in  SAMPLE_W  signed x of pair.
- `y_val`  in  SAMPLE_W  signed y of pair.
- `bit_stall`  out  1  upstream must withhold `axiiv` while high.
- `line_we`  out  1  line RAM write enable.
- `line_addr`  out  ADDR_W  line RAM address.
- `line_data`  out  SAMPLE_W  line RAM write data.
- `busy`  out  1  high from cycle after `start` until `done`.
- `done`  out  1  one-cycle pulse, granule fully written.
- `err_extra`  out  1  sticky; pair arrived outside DECODE. Cleared by `start`.

## Operation
- States: IDLE, DECODE, DRAIN, ZFILL, DONE.
- IDLE: on `start`, latch clamped `big_values` into `bv`, clear pair count, `wr_addr`, `err_extra`. Next state is DECODE if `bv`≠0, else ZFILL.
- DECODE: every `axiov` pushes {x,y} into the FIFO and increments `pair_cnt`. When the push makes `pair_cnt`==`bv`, go to DRAIN.
- DRAIN: no pushes. Go to ZFILL when the FIFO is empty and no half-written pair is outstanding.
- Writer (DECODE/DRAIN): with the FIFO non-empty, write x to `wr_addr`, then y to `wr_addr`+1, then pop. One line per cycle, so one pair every 2 cycles.
- ZFILL: write 0 to `wr_addr`..NUM_LINES-1, one per cycle. After line 575 go to DONE.
- DONE: assert `done` for one cycle, then IDLE.
- `axiov` in IDLE/DRAIN/ZFILL/DONE: pair dropped, `err_extra` set.
- `start` while `busy`: ignored.
- `bit_stall` = FIFO count ≥ FIFO_DEPTH-2. This leaves room for the ≤1 pair already in flight in the decoder.
- FIFO push when full (upstream ignored stall): pair dropped, `err_extra` set, count unchanged.
- Simultaneous push and pop: count unchanged, both take effect.
- Sign preserved. `line_data` is a direct copy, no arithmetic.

## Timing
- Reset values: state IDLE, `line_we`=0, `line_addr`=0, `line_data`=0, `busy`=0, `done`=0, `err_extra`=0, `bit_stall`=0, FIFO empty.
- All outputs registered. `line_we`/`addr`/`data` change together.
- Latency: an `axiov` at cycle t into an empty FIFO gives x written at t+2 (`line_we` high) and y at t+3.
- `bit_stall` is registered. It rises the cycle after the count reaches threshold.
- Total granule duration from `start`: one cycle into the run state, then 576 line writes plus any decoder idle gaps, then the DONE cycle.
- Asserting `rst_n` low mid-granule aborts immediately to reset values. Partial RAM contents are undefined.

## Structure
- Shared package `mp3_huff_pkg`: `NUM_LINES`, `MAX_BIG_VALUES`=288, `hlw_state_t` enum, `pair_t` struct {x, y}.
- Sub-module `huff_pair_fifo`: synchronous FIFO of `pair_t` with `push`, `pop`, `full`, `empty`, `count`, and async active-low reset.
- Top holds the FSM, pair/address counters, the x/y phase bit and the stall logic.

## Test plan
- `big_values`=2, pairs (1,-1) then (0,2) spaced 4 cycles → lines 0..3 = 1,-1,0,2. Lines 4..575 = 0, one `done`, `err_extra`=0.
- `big_values`=0 → 576 zero writes, addresses 0..575 contiguous, `done` at line 575 + 1 cycle.
- `big_values`=8, `axiov` every cycle with stall honoured by the model → `bit_stall` asserts at count 2, no drops, 16 lines in order.
- `big_values`=400 → clamped to 288. Lines 0..575 all from pairs, no ZFILL writes.
- Extra pair after 3rd of `big_values`=3 → `err_extra`=1, line 6 = 0.
- `rst_n` low during ZFILL at line 300 → all outputs reset next edge. A fresh `start` with `big_values`=1 writes from line 0.

Source files
------------

// File: rtl/mp3_huff_pkg.sv
// Shared types and constants for the Huffman line-writer path.
package mp3_huff_pkg;

    localparam int NUM_LINES      = 576;
    localparam int MAX_BIG_VALUES = 288;
    localparam int SAMPLE_W       = 16;
    localparam int ADDR_W         = 10;
    localparam int BV_W           = 9;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_DRAIN  = 3'd2,
        S_ZFILL  = 3'd3,
        S_DONE   = 3'd4
    } hlw_state_t;

    typedef struct packed {
        logic signed [SAMPLE_W-1:0] x;
        logic signed [SAMPLE_W-1:0] y;
    } pair_t;

    // A granule cannot hold more than MAX_BIG_VALUES pairs (2 lines each).
    function automatic logic [BV_W-1:0] clamp_bv(input logic [BV_W-1:0] bv);
        return (bv > BV_W'(MAX_BIG_VALUES)) ? BV_W'(MAX_BIG_VALUES) : bv;
    endfunction

endpackage

// File: rtl/huff_pair_fifo.sv
// Small synchronous FIFO of decoded (x, y) pairs. Push when full and pop
// when empty are ignored; the owner decides what a refused push means.
module huff_pair_fifo
    import mp3_huff_pkg::*;
#(
    parameter int DEPTH = 4
)
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  pair_t                  wdata_i,
    output pair_t                  rdata_o,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

    pair_t         mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata_o = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/huff_line_writer.sv
// Writes decoded Huffman pairs as consecutive frequency lines into the
// granule line RAM, then zero-fills the remainder of the 576-line granule.
//
// Handshake: axiov is a valid-only strobe (no ready); a pair is taken on
// every cycle axiov is high. bit_stall is the back-pressure: while it is high
// the upstream must not feed new bits, and the FIFO keeps two free slots so a
// pair already in flight when stall rises is still accepted.
module huff_line_writer
    import mp3_huff_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
)
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [BV_W-1:0]            big_values,
    input  logic                       axiov,
    input  logic signed [SAMPLE_W-1:0] x_val,
    input  logic signed [SAMPLE_W-1:0] y_val,
    output logic                       bit_stall,
    output logic                       line_we,
    output logic [ADDR_W-1:0]          line_addr,
    output logic [SAMPLE_W-1:0]        line_data,
    output logic                       busy,
    output logic                       done,
    output logic                       err_extra,
    output hlw_state_t                 dbg_state
);

    localparam int               CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] STALL_LVL = CNT_W'(FIFO_DEPTH - 2);
    localparam logic [ADDR_W-1:0] LAST_LINE = ADDR_W'(NUM_LINES - 1);
    localparam logic [ADDR_W-1:0] END_LINE  = ADDR_W'(NUM_LINES);

    hlw_state_t         state_q, state_d;
    logic [BV_W-1:0]    bv_q, bv_d;
    logic [BV_W-1:0]    pair_cnt_q, pair_cnt_d;
    logic [BV_W-1:0]    pair_cnt_inc;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic               phase_q, phase_d;     // 0: x next, 1: y next
    logic               line_we_q, line_we_d;
    logic [ADDR_W-1:0]  line_addr_q, line_addr_d;
    logic [SAMPLE_W-1:0] line_data_q, line_data_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               stall_q, stall_d;

    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    pair_t              fifo_wdata;
    pair_t              fifo_head;

    assign fifo_wdata   = {x_val, y_val};
    assign pair_cnt_inc = pair_cnt_q + BV_W'(1);

    huff_pair_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wdata_i (fifo_wdata),
        .rdata_o (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Next-state, counters, line writer and registered-output next values.
    always_comb begin
        state_d     = state_q;
        bv_d        = bv_q;
        pair_cnt_d  = pair_cnt_q;
        wr_addr_d   = wr_addr_q;
        phase_d     = phase_q;
        line_we_d   = 1'b0;
        line_addr_d = line_addr_q;
        line_data_d = line_data_q;
        done_d      = 1'b0;
        err_d       = err_q;
        fifo_push   = 1'b0;
        fifo_pop    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    bv_d       = clamp_bv(big_values);
                    pair_cnt_d = '0;
                    wr_addr_d  = '0;
                    phase_d    = 1'b0;
                    err_d      = 1'b0;
                    state_d    = (clamp_bv(big_values) != '0) ? S_DECODE : S_ZFILL;
                end
            end
            S_DECODE: begin
                if (axiov) begin
                    if (!fifo_full) begin
                        fifo_push  = 1'b1;
                        pair_cnt_d = pair_cnt_inc;
                        if (pair_cnt_inc == bv_q) state_d = S_DRAIN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (fifo_empty && !phase_q) begin
                    state_d = (wr_addr_q == END_LINE) ? S_DONE : S_ZFILL;
                end
            end
            S_ZFILL: begin
                line_we_d   = 1'b1;
                line_addr_d = wr_addr_q;
                line_data_d = '0;
                wr_addr_d   = wr_addr_q + ADDR_W'(1);
                if (wr_addr_q == LAST_LINE) state_d = S_DONE;
            end
            S_DONE: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Pair writer: x then y of the head pair, pop after y.
        if ((state_q == S_DECODE || state_q == S_DRAIN) && !fifo_empty) begin
            line_we_d   = 1'b1;
            line_addr_d = wr_addr_q;
            line_data_d = phase_q ? fifo_head.y : fifo_head.x;
            wr_addr_d   = wr_addr_q + ADDR_W'(1);
            phase_d     = !phase_q;
            fifo_pop    = phase_q;
        end

        // A pair arriving outside DECODE has nowhere to go.
        if (axiov && state_q != S_DECODE) err_d = 1'b1;

        busy_d  = (state_d != S_IDLE);
        stall_d = (fifo_count >= STALL_LVL);
    end

    // State and output registers; reset aborts any granule in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            bv_q        <= '0;
            pair_cnt_q  <= '0;
            wr_addr_q   <= '0;
            phase_q     <= 1'b0;
            line_we_q   <= 1'b0;
            line_addr_q <= '0;
            line_data_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            stall_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            bv_q        <= bv_d;
            pair_cnt_q  <= pair_cnt_d;
            wr_addr_q   <= wr_addr_d;
            phase_q     <= phase_d;
            line_we_q   <= line_we_d;
            line_addr_q <= line_addr_d;
            line_data_q <= line_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            stall_q     <= stall_d;
        end
    end

    assign bit_stall = stall_q;
    assign line_we   = line_we_q;
    assign line_addr = line_addr_q;
    assign line_data = line_data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err_extra = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_huff_line_writer.sv
// Bench for huff_line_writer: random pairs, reference line image built from
// the granule rules, scoreboard queue drained by a line-write monitor.
module tb_huff_line_writer;
    import mp3_huff_pkg::*;

    localparam int EXP_W = ADDR_W + SAMPLE_W;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic                       start;
    logic [BV_W-1:0]            big_values;
    logic                       axiov;
    logic signed [SAMPLE_W-1:0] x_val;
    logic signed [SAMPLE_W-1:0] y_val;
    logic                       bit_stall;
    logic                       line_we;
    logic [ADDR_W-1:0]          line_addr;
    logic [SAMPLE_W-1:0]        line_data;
    logic                       busy;
    logic                       done;
    logic                       err_extra;
    hlw_state_t                 dbg_state;

    int vectors     = 0;
    int miscompares = 0;
    logic [EXP_W-1:0] exp_q[$];
    logic [EXP_W-1:0] mon_e;

    int cyc           = 0;
    int done_cnt      = 0;
    int done_cyc      = 0;
    int l575_cyc      = 0;
    int first_we_cyc  = -1;
    int last_axiov_cyc = 0;
    bit stall_seen    = 0;

    logic signed [SAMPLE_W-1:0] pair_x [MAX_BIG_VALUES];
    logic signed [SAMPLE_W-1:0] pair_y [MAX_BIG_VALUES];

    huff_line_writer #(.FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .big_values (big_values),
        .axiov      (axiov),
        .x_val      (x_val),
        .y_val      (y_val),
        .bit_stall  (bit_stall),
        .line_we    (line_we),
        .line_addr  (line_addr),
        .line_data  (line_data),
        .busy       (busy),
        .done       (done),
        .err_extra  (err_extra),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, required finish before it");
        $fatal(1, "watchdog");
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (bit_stall) stall_seen = 1;
            if (done) begin
                done_cnt = done_cnt + 1;
                done_cyc = cyc;
            end
            if (line_we) begin
                if (line_addr == ADDR_W'(0) && first_we_cyc < 0) first_we_cyc = cyc;
                if (line_addr == ADDR_W'(NUM_LINES - 1)) l575_cyc = cyc;
                vectors = vectors + 1;
                if (exp_q.size() == 0) begin
                    miscompares = miscompares + 1;
                    $display("FAIL line_write: got addr=%0d data=%0d, required no write",
                             line_addr, $signed(line_data));
                end else begin
                    mon_e = exp_q.pop_front();
                    if ({line_addr, line_data} !== mon_e) begin
                        miscompares = miscompares + 1;
                        $display("FAIL line_write: got addr=%0d data=%0d, required addr=%0d data=%0d",
                                 line_addr, $signed(line_data),
                                 mon_e[EXP_W-1 -: ADDR_W], $signed(mon_e[SAMPLE_W-1:0]));
                    end
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors = vectors + 1;
        if (act !== req) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_line_we"},   32'(line_we),   0);
        check({tag, "_line_addr"}, 32'(line_addr), 0);
        check({tag, "_line_data"}, 32'(line_data), 0);
        check({tag, "_busy"},      32'(busy),      0);
        check({tag, "_done"},      32'(done),      0);
        check({tag, "_err_extra"}, 32'(err_extra), 0);
        check({tag, "_bit_stall"}, 32'(bit_stall), 0);
        check({tag, "_state"},     32'(dbg_state), 32'(S_IDLE));
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        start      = 1'b0;
        big_values = '0;
        axiov      = 1'b0;
        x_val      = '0;
        y_val      = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // ---------------- driver tasks ----------------
    task automatic pulse_start(input int bv);
        start      = 1'b1;
        big_values = BV_W'(bv);
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic send_pair(input logic signed [SAMPLE_W-1:0] x,
                             input logic signed [SAMPLE_W-1:0] y,
                             input bit honour);
        int guard;
        guard = 0;
        if (honour) begin
            while (bit_stall && guard < 200) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 200) check("stall_release_timeout", 32'(bit_stall), 0);
        end
        axiov = 1'b1;
        x_val = x;
        y_val = y;
        last_axiov_cyc = cyc;
        @(negedge clk);
        axiov = 1'b0;
    endtask

    // Reference line image: pairs fill lines 0..2*eff-1, zeros fill the rest.
    task automatic load_expected(input int eff);
        for (int i = 0; i < eff; i++) begin
            exp_q.push_back({ADDR_W'(2*i),     SAMPLE_W'(pair_x[i])});
            exp_q.push_back({ADDR_W'(2*i + 1), SAMPLE_W'(pair_y[i])});
        end
        for (int a = 2*eff; a < NUM_LINES; a++) begin
            exp_q.push_back({ADDR_W'(a), SAMPLE_W'(0)});
        end
    endtask

    task automatic run_granule(input int bv, input int gap_min, input int gap_max,
                               input bit preset, input bit extra,
                               input bit restart_busy, input bit exp_err,
                               input string tag);
        int eff;
        int d0;
        int guard;
        eff = (bv > MAX_BIG_VALUES) ? MAX_BIG_VALUES : bv;
        if (!preset) begin
            for (int i = 0; i < eff; i++) begin
                pair_x[i] = SAMPLE_W'($urandom);
                pair_y[i] = SAMPLE_W'($urandom);
            end
        end
        load_expected(eff);
        stall_seen   = 0;
        first_we_cyc = -1;
        d0           = done_cnt;
        pulse_start(bv);
        for (int i = 0; i < eff; i++) begin
            repeat ($urandom_range(gap_max, gap_min)) @(negedge clk);
            send_pair(pair_x[i], pair_y[i], 1'b1);
        end
        if (extra) send_pair(SAMPLE_W'($urandom), SAMPLE_W'($urandom), 1'b0);
        if (restart_busy) pulse_start(5);
        guard = 0;
        while (done_cnt == d0 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        check({tag, "_done_seen"}, 32'(done_cnt != d0), 1);
        repeat (3) @(negedge clk);
        check({tag, "_done_pulses"}, 32'(done_cnt - d0), 1);
        check({tag, "_lines_left"},  32'(exp_q.size()), 0);
        check({tag, "_err_extra"},   32'(err_extra), 32'(exp_err));
        check({tag, "_busy_after"},  32'(busy), 0);
        exp_q.delete();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int guard;
        do_reset();
        check_reset_outputs("reset");

        // Two directed pairs spaced 4 cycles; latency from first strobe to x write.
        pair_x[0] = 16'sd1;  pair_y[0] = -16'sd1;
        pair_x[1] = 16'sd0;  pair_y[1] = 16'sd2;
        run_granule(2, 3, 3, 1'b1, 1'b0, 1'b0, 1'b0, "bv2");
        check("bv2_first_x_latency", 32'(first_we_cyc - (last_axiov_cyc - 4)), 2);

        // No pairs: pure zero fill, done one cycle after line 575.
        run_granule(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, "bv0");
        check("bv0_done_after_575", 32'(done_cyc - l575_cyc), 1);

        // Extra pair after the last one is dropped and flagged.
        run_granule(3, 0, 1, 1'b0, 1'b1, 1'b0, 1'b1, "bv3_extra");

        // Back-to-back pairs, stall honoured; start also clears the sticky error.
        run_granule(8, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, "bv8_burst");
        check("bv8_stall_seen", 32'(stall_seen), 1);

        // Oversized pair count clamps to a full granule of pairs.
        run_granule(400, 0, 2, 1'b0, 1'b0, 1'b0, 1'b0, "bv400");

        // Reset in the middle of the zero fill.
        load_expected(0);
        pulse_start(0);
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!(line_we && line_addr == ADDR_W'(300)) && guard < 1000);
        check("zfill_reached_300", 32'(guard < 1000), 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_granule(1, 0, 2, 1'b0, 1'b0, 1'b0, 1'b0, "after_reset");

        // Random granules, some with a start pulse while busy.
        for (int g = 0; g < 6; g++) begin
            run_granule(int'($urandom_range(24, 0)), 0, 3, 1'b0, 1'b0,
                        1'($urandom_range(1, 0)), 1'b0, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
